// File: rtl/packer_pkg.sv
// packer_pkg: shared state, widths and byte assembly for the nibble/byte packers
package packer_pkg;
   typedef enum logic {EMPTY, HALF} pack_state_e;
   localparam int NIBBLE_W = 4;
   localparam int BYTE_W = 8;
   function automatic logic [BYTE_W-1:0] pack_byte(
      input logic [NIBBLE_W-1:0] first,
      input logic [NIBBLE_W-1:0] second,
      input logic                msb_first
   );
      return msb_first ? {first, second} : {second, first};
   endfunction
endpackage

// File: rtl/nibble_byte_packer_out_reg.sv
// pack_out_reg: one-byte output register with handshake counter
// A load wins over a same-cycle drain, so back-to-back bytes keep out_valid high.
module pack_out_reg
   import packer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [BYTE_W-1:0] i_byte,
   input  logic              i_partial,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [BYTE_W-1:0] o_byte,
   output logic              o_partial,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_slot_free
);
   logic              r_valid;
   logic [BYTE_W-1:0] r_byte;
   logic              r_partial;
   logic [CNT_W-1:0]  r_count;
   logic              w_out_fire;
   assign w_out_fire  = r_valid && i_ready;
   assign o_slot_free = !r_valid || i_ready;
   assign o_valid     = r_valid;
   assign o_byte      = r_byte;
   assign o_partial   = r_partial;
   assign o_count     = r_count;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_byte    <= '0;
         r_partial <= 1'b0;
         r_count   <= '0;
      end else begin
         if (i_load) begin
            r_valid   <= 1'b1;
            r_byte    <= i_byte;
            r_partial <= i_partial;
         end else if (w_out_fire) begin
            r_valid <= 1'b0;
         end
         if (w_out_fire) r_count <= r_count + 1'b1;
      end
   end
endmodule

// File: rtl/nibble_byte_packer.sv
// nibble_byte_packer: packs 4-bit nibbles into 8-bit bytes with valid/ready on both sides
// A last nibble arriving with nothing held is flushed as a zero-padded partial byte.
module nibble_byte_packer
   import packer_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b0,
   parameter int CNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NIBBLE_W-1:0] in_nibble,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BYTE_W-1:0]   out_byte,
   output logic                out_partial,
   output logic [CNT_W-1:0]    byte_count
);
   pack_state_e         r_state;
   logic [NIBBLE_W-1:0] r_hold;
   logic                w_slot_free;
   logic                w_in_fire;
   logic                w_completes;
   logic [BYTE_W-1:0]   w_byte;
   assign in_ready    = w_slot_free || (r_state == EMPTY && !in_last);
   assign w_in_fire   = in_valid && in_ready;
   assign w_completes = r_state == HALF || in_last;
   assign w_byte      = r_state == HALF ? pack_byte(r_hold, in_nibble, MSB_FIRST)
                                        : pack_byte(in_nibble, 4'h0, MSB_FIRST);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= EMPTY;
         r_hold  <= '0;
      end else if (w_in_fire) begin
         r_state <= w_completes ? EMPTY : HALF;
         if (!w_completes) r_hold <= in_nibble;
      end
   end
   pack_out_reg #(.CNT_W(CNT_W)) u_out (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_in_fire && w_completes),
      .i_byte     (w_byte),
      .i_partial  (r_state == EMPTY),
      .i_ready    (out_ready),
      .o_valid    (out_valid),
      .o_byte     (out_byte),
      .o_partial  (out_partial),
      .o_count    (byte_count),
      .o_slot_free(w_slot_free)
   );
endmodule
